// File: rtl/scarf_edge_counter_scheduler_if.sv
// Regmap <-> sequencer bundle: config/start/abort in, strobes and status out.
interface scarf_edge_counter_scheduler_if #(
  parameter int GATE_W = 32
);
  logic              start;
  logic              abort;
  logic              mode;
  logic [3:0]        chan_mask;
  logic [GATE_W-1:0] gate_cycles;
  logic [3:0]        clr;
  logic [3:0]        enable;
  logic [3:0]        capture;
  logic [1:0]        active_chan;
  logic              busy;
  logic              done;
  logic              err;
  logic              aborted;
  logic [3:0]        done_mask;

  modport master (
    output start, abort, mode, chan_mask, gate_cycles,
    input  clr, enable, capture, active_chan, busy, done, err, aborted, done_mask
  );

  modport slave (
    input  start, abort, mode, chan_mask, gate_cycles,
    output clr, enable, capture, active_chan, busy, done, err, aborted, done_mask
  );
endinterface

// File: rtl/scarf_edge_counter_scheduler.sv
// SCARF edge-counter measurement sequencer: clear, gate, settle and capture
// the four counters, concurrently or one channel at a time.
module scarf_esc_lane (
  input  logic clk,
  input  logic rst_n_sync,
  input  logic sel_i,
  input  logic arm_i,
  input  logic gate_i,
  input  logic cap_i,
  input  logic dm_clr_i,
  output logic clr_o,
  output logic en_o,
  output logic cap_o,
  output logic dm_o
);
  logic clr_q, en_q, cap_q, dm_q;

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      clr_q <= 1'b0;
      en_q  <= 1'b0;
      cap_q <= 1'b0;
      dm_q  <= 1'b0;
    end else begin
      clr_q <= sel_i & arm_i;
      en_q  <= sel_i & gate_i;
      cap_q <= sel_i & cap_i;
      dm_q  <= dm_clr_i ? 1'b0 : (dm_q | (sel_i & cap_i));
    end
  end

  assign clr_o = clr_q;
  assign en_o  = en_q;
  assign cap_o = cap_q;
  assign dm_o  = dm_q;
endmodule

module scarf_edge_counter_scheduler #(
  parameter int SETTLE_CYCLES = 4,
  parameter int GATE_W        = 32
) (
  input logic                          clk,
  input logic                          rst_n_sync,
  scarf_edge_counter_scheduler_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int CH_W      = 2;

  typedef enum logic [2:0] {IDLE, ARM, GATE, SETTLE, CAPTURE} state_e;

  state_e                 state_q, state_d;
  logic [GATE_W-1:0]      gcnt_q, gcnt_d;
  logic [7:0]             scnt_q, scnt_d;
  logic [CH_W-1:0]        chan_q, chan_d;
  logic                   mode_q, mode_d;
  logic [NUM_LANES-1:0]   mask_q, mask_d;
  logic [GATE_W-1:0]      gate_q, gate_d;
  logic                   busy_q, done_q, err_q, abrt_q;
  logic                   err_d, done_d, abrt_d, dm_clr;
  logic [CH_W:0]          nxt;
  logic [NUM_LANES-1:0]   set_d;
  logic                   ph_arm, ph_gate, ph_cap;
  logic [NUM_LANES-1:0]   clr_w, en_w, cap_w, dm_w;

  // Lowest set mask bit at or above 'from'; MSB flags whether one exists.
  function automatic logic [CH_W:0] pick(input logic [NUM_LANES-1:0] m, input int from);
    pick = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (m[i] && i >= from) pick = {1'b1, CH_W'(i)};
  endfunction

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    scnt_d  = scnt_q;
    chan_d  = chan_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    gate_d  = gate_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    abrt_d  = 1'b0;
    dm_clr  = 1'b0;
    nxt     = '0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.chan_mask == '0 || bus.gate_cycles == '0) begin
            err_d = 1'b1;
          end else begin
            mode_d  = bus.mode;
            mask_d  = bus.chan_mask;
            gate_d  = bus.gate_cycles;
            dm_clr  = 1'b1;
            nxt     = pick(bus.chan_mask, 0);
            chan_d  = bus.mode ? nxt[CH_W-1:0] : '0;
            state_d = ARM;
          end
        end
      end
      ARM: begin
        gcnt_d  = gate_q;
        state_d = GATE;
      end
      GATE: begin
        // Terminal count is 1, so an all-ones load never wraps.
        if (gcnt_q == GATE_W'(1)) begin
          scnt_d  = 8'(SETTLE_CYCLES);
          state_d = SETTLE;
        end else begin
          gcnt_d = gcnt_q - GATE_W'(1);
        end
      end
      SETTLE: begin
        if (scnt_q == 8'd1) state_d = CAPTURE;
        else                scnt_d  = scnt_q - 8'd1;
      end
      CAPTURE: begin
        nxt = pick(mask_q, int'(chan_q) + 1);
        if (mode_q && nxt[CH_W]) begin
          chan_d  = nxt[CH_W-1:0];
          state_d = ARM;
        end else begin
          chan_d  = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides whatever the phase logic decided, including a done.
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      chan_d  = '0;
      done_d  = 1'b0;
      abrt_d  = 1'b1;
    end
  end

  assign set_d   = mode_d ? (NUM_LANES'(1) << chan_d) : mask_d;
  assign ph_arm  = (state_d == ARM);
  assign ph_gate = (state_d == GATE);
  assign ph_cap  = (state_d == CAPTURE);

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q <= IDLE;
      gcnt_q  <= '0;
      scnt_q  <= '0;
      chan_q  <= '0;
      mode_q  <= 1'b0;
      mask_q  <= '0;
      gate_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      scnt_q  <= scnt_d;
      chan_q  <= chan_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      gate_q  <= gate_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
      abrt_q  <= abrt_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    scarf_esc_lane u_lane (
      .clk        (clk),
      .rst_n_sync (rst_n_sync),
      .sel_i      (set_d[g]),
      .arm_i      (ph_arm),
      .gate_i     (ph_gate),
      .cap_i      (ph_cap),
      .dm_clr_i   (dm_clr),
      .clr_o      (clr_w[g]),
      .en_o       (en_w[g]),
      .cap_o      (cap_w[g]),
      .dm_o       (dm_w[g])
    );
  end

  assign bus.clr         = clr_w;
  assign bus.enable      = en_w;
  assign bus.capture     = cap_w;
  assign bus.done_mask   = dm_w;
  assign bus.active_chan = chan_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.aborted     = abrt_q;
endmodule

// File: tb/tb_scarf_edge_counter_scheduler.sv
// Scoreboard bench: stimulus queues expected strobe/status events, a negedge
// monitor pops and checks them whenever the sequencer emits one.
module tb_scarf_edge_counter_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scarf_edge_counter_scheduler_if #(.GATE_W(32)) bus();

  scarf_edge_counter_scheduler #(.SETTLE_CYCLES(4), .GATE_W(32)) dut (
    .clk        (clk),
    .rst_n_sync (rst_n),
    .bus        (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] clr, cap;
    logic       done, err, ab, busy;
    logic [1:0] act;
    logic [3:0] dm;
    int         en_cnt;
    logic [3:0] en_val;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;

  function automatic void push(int c, logic [3:0] clr, logic [3:0] cap, logic done,
                               logic err, logic ab, logic busy, logic [1:0] act,
                               logic [3:0] dm, int en_cnt, logic [3:0] en_val);
    ev_t e;
    e.cyc = c; e.clr = clr; e.cap = cap; e.done = done; e.err = err; e.ab = ab;
    e.busy = busy; e.act = act; e.dm = dm; e.en_cnt = en_cnt; e.en_val = en_val;
    q.push_back(e);
  endfunction

  // Monitor: enable is summarised between events (cycle count, single pattern).
  initial begin
    int         en_run;
    logic [3:0] en_seen;
    logic       en_mix;
    ev_t        e;
    en_run = 0; en_seen = '0; en_mix = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_run = 0; en_seen = '0; en_mix = 1'b0;
      end else begin
        if (bus.enable != '0) begin
          if (en_seen != '0 && bus.enable != en_seen) en_mix = 1'b1;
          en_seen = bus.enable;
          en_run++;
        end
        if (bus.clr != '0 || bus.capture != '0 || bus.done || bus.err || bus.aborted) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event cyc=%0d clr=%h cap=%h done=%b err=%b aborted=%b",
                     cyc, bus.clr, bus.capture, bus.done, bus.err, bus.aborted);
          end else begin
            e = q.pop_front();
            if (cyc != e.cyc || bus.clr != e.clr || bus.capture != e.cap ||
                bus.done != e.done || bus.err != e.err || bus.aborted != e.ab ||
                bus.busy != e.busy || bus.active_chan != e.act || bus.done_mask != e.dm ||
                en_run != e.en_cnt || en_seen != e.en_val || en_mix) begin
              bad++;
              $display("FAIL event got cyc=%0d clr=%h cap=%h done=%b err=%b ab=%b busy=%b act=%0d dm=%h en_cnt=%0d en=%h mix=%b | want cyc=%0d clr=%h cap=%h done=%b err=%b ab=%b busy=%b act=%0d dm=%h en_cnt=%0d en=%h",
                       cyc, bus.clr, bus.capture, bus.done, bus.err, bus.aborted, bus.busy,
                       bus.active_chan, bus.done_mask, en_run, en_seen, en_mix,
                       e.cyc, e.clr, e.cap, e.done, e.err, e.ab, e.busy, e.act, e.dm,
                       e.en_cnt, e.en_val);
            end
          end
          en_run = 0; en_seen = '0; en_mix = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic pulse_start(input logic m, input logic [3:0] mk, input logic [31:0] g);
    bus.mode = m; bus.chan_mask = mk; bus.gate_cycles = g; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout pending=%0d want=0", q.size());
      q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic check_idle_zero(input string name);
    logic [24:0] got;
    got = {bus.clr, bus.enable, bus.capture, bus.active_chan, bus.busy, bus.done,
           bus.err, bus.aborted, bus.done_mask};
    total++;
    if (got != '0) begin
      bad++;
      $display("FAIL %s got=%h want=0", name, got);
    end
  endtask

  initial begin
    int c0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0;
    bus.chan_mask = '0; bus.gate_cycles = '0;
    repeat (3) tick();
    check_idle_zero("reset_state");
    rst_n = 1'b1;
    tick();

    // Concurrent, all channels, G=10.
    c0 = cyc;
    push(c0+1,  4'hF, 4'h0, 0, 0, 0, 1, 2'd0, 4'h0, 0,  4'h0);
    push(c0+16, 4'h0, 4'hF, 0, 0, 0, 1, 2'd0, 4'hF, 10, 4'hF);
    push(c0+17, 4'h0, 4'h0, 1, 0, 0, 0, 2'd0, 4'hF, 0,  4'h0);
    pulse_start(1'b0, 4'hF, 32'd10);
    drain(60);

    // Sequential 0101, G=10.
    c0 = cyc;
    push(c0+1,  4'h1, 4'h0, 0, 0, 0, 1, 2'd0, 4'h0, 0,  4'h0);
    push(c0+16, 4'h0, 4'h1, 0, 0, 0, 1, 2'd0, 4'h1, 10, 4'h1);
    push(c0+17, 4'h4, 4'h0, 0, 0, 0, 1, 2'd2, 4'h1, 0,  4'h0);
    push(c0+32, 4'h0, 4'h4, 0, 0, 0, 1, 2'd2, 4'h5, 10, 4'h4);
    push(c0+33, 4'h0, 4'h0, 1, 0, 0, 0, 2'd0, 4'h5, 0,  4'h0);
    pulse_start(1'b1, 4'b0101, 32'd10);
    drain(80);

    // Rejects: empty mask, then zero gate; done_mask untouched.
    c0 = cyc;
    push(c0+1, 4'h0, 4'h0, 0, 1, 0, 0, 2'd0, 4'h5, 0, 4'h0);
    pulse_start(1'b1, 4'h0, 32'd10);
    drain(10);
    c0 = cyc;
    push(c0+1, 4'h0, 4'h0, 0, 1, 0, 0, 2'd0, 4'h5, 0, 4'h0);
    pulse_start(1'b0, 4'hF, 32'd0);
    drain(10);

    // Start while busy with changed inputs: ignored, latched config holds.
    c0 = cyc;
    push(c0+1,  4'h3, 4'h0, 0, 0, 0, 1, 2'd0, 4'h0, 0, 4'h0);
    push(c0+9,  4'h0, 4'h3, 0, 0, 0, 1, 2'd0, 4'h3, 3, 4'h3);
    push(c0+10, 4'h0, 4'h0, 1, 0, 0, 0, 2'd0, 4'h3, 0, 4'h0);
    pulse_start(1'b0, 4'h3, 32'd3);
    go_to(c0+3);
    pulse_start(1'b1, 4'hF, 32'd1);
    drain(40);

    // Abort during ch1 gate of a sequential 0011 run.
    c0 = cyc;
    push(c0+1,  4'h1, 4'h0, 0, 0, 0, 1, 2'd0, 4'h0, 0,  4'h0);
    push(c0+16, 4'h0, 4'h1, 0, 0, 0, 1, 2'd0, 4'h1, 10, 4'h1);
    push(c0+17, 4'h2, 4'h0, 0, 0, 0, 1, 2'd1, 4'h1, 0,  4'h0);
    push(c0+21, 4'h0, 4'h0, 0, 0, 1, 0, 2'd0, 4'h1, 3,  4'h2);
    pulse_start(1'b1, 4'b0011, 32'd10);
    go_to(c0+20);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    drain(60);

    // Abort and start together while idle: nothing happens, no err.
    bus.abort = 1'b1;
    pulse_start(1'b0, 4'hF, 32'd5);
    bus.abort = 1'b0;
    repeat (4) tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_start_idle busy got=%b want=0", bus.busy);
    end

    // Minimum gate, concurrent on channel 3 only.
    c0 = cyc;
    push(c0+1, 4'h8, 4'h0, 0, 0, 0, 1, 2'd0, 4'h0, 0, 4'h0);
    push(c0+7, 4'h0, 4'h8, 0, 0, 0, 1, 2'd0, 4'h8, 1, 4'h8);
    push(c0+8, 4'h0, 4'h0, 1, 0, 0, 0, 2'd0, 4'h8, 0, 4'h0);
    pulse_start(1'b0, 4'h8, 32'd1);
    drain(30);

    // Sequential 1010, G=2: channel skip from 1 to 3.
    c0 = cyc;
    push(c0+1,  4'h2, 4'h0, 0, 0, 0, 1, 2'd1, 4'h0, 0, 4'h0);
    push(c0+8,  4'h0, 4'h2, 0, 0, 0, 1, 2'd1, 4'h2, 2, 4'h2);
    push(c0+9,  4'h8, 4'h0, 0, 0, 0, 1, 2'd3, 4'h2, 0, 4'h0);
    push(c0+16, 4'h0, 4'h8, 0, 0, 0, 1, 2'd3, 4'hA, 2, 4'h8);
    push(c0+17, 4'h0, 4'h0, 1, 0, 0, 0, 2'd0, 4'hA, 0, 4'h0);
    pulse_start(1'b1, 4'b1010, 32'd2);
    drain(40);

    // Full-scale gate accepted, then async reset mid-gate.
    c0 = cyc;
    push(c0+1, 4'hF, 4'h0, 0, 0, 0, 1, 2'd0, 4'h0, 0, 4'h0);
    pulse_start(1'b0, 4'hF, 32'hFFFF_FFFF);
    go_to(c0+5);
    #2 rst_n = 1'b0;
    #1 check_idle_zero("async_reset_mid_gate");
    tick();
    rst_n = 1'b1;
    drain(10);
    check_idle_zero("after_reset_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scarf_edge_counter_scheduler.md
Name: scarf_edge_counter_scheduler

Overview:
Measurement sequencer for the four-channel SCARF edge-counter block. It clears, gates and snapshots the counters over a programmable window, either on all selected channels at once or one channel at a time in index order. Configuration and start/abort come from a SCARF regmap. Its clr/enable/capture strobes drive the counter datapath; its status goes back to the regmap for readback.

Parameters:
SETTLE_CYCLES, 4, idle cycles after the gate closes before capture, so counter input synchronisers drain; legal range 1..255.
GATE_W, 32, width of the gate-length counter and of gate_cycles.

Ports:
clk  input  1  system clock
rst_n_sync  input  1  asynchronous active-low reset, synchronously deasserted
start  input  1  single-cycle request to begin a measurement
abort  input  1  single-cycle request to terminate the measurement
mode  input  1  0 = concurrent (all masked channels together), 1 = sequential (one channel at a time)
chan_mask  input  4  channels to measure
gate_cycles  input  GATE_W  gate window length in clk cycles
clr  output  4  one-cycle counter clear, per channel
enable  output  4  counter gate, per channel
capture  output  4  one-cycle snapshot strobe, per channel
active_chan  output  2  channel currently sequenced; 0 in concurrent mode or when idle
busy  output  1  measurement in progress
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse: start rejected
aborted  output  1  one-cycle pulse: abort honoured
done_mask  output  4  sticky, one bit per channel captured since the last accepted start

Behaviour:
- Reset: all outputs 0; FSM in IDLE; gate counter and latched config cleared.
- All outputs are registered.
- FSM states: IDLE, ARM, GATE, SETTLE, CAPTURE.
- IDLE + start:
  - If chan_mask==0 or gate_cycles==0: err=1 for one cycle, remain in IDLE.
  - Otherwise: latch mode, chan_mask and gate_cycles; clear done_mask; go to ARM.
- start while busy is ignored. Latched values are immune to input changes during the run.
- Channel set per phase: concurrent mode uses the whole latched mask. Sequential mode uses the single channel active_chan, starting at the lowest set bit.
- ARM (1 cycle): clr asserted for the channel set; busy=1; gate counter loaded with gate_cycles. Next state GATE.
- GATE: enable asserted for the channel set for exactly gate_cycles cycles. The counter decrements each cycle; when it reaches 1, go to SETTLE.
- SETTLE: enable=0 for exactly SETTLE_CYCLES cycles, then CAPTURE.
- CAPTURE (1 cycle): capture asserted for the channel set; those done_mask bits are set.
  - Sequential mode with a higher set mask bit remaining: active_chan advances to it, go to ARM.
  - Otherwise: go to IDLE with done=1 and busy=0 in that same cycle.
- Latency, concurrent mode: start sampled at cycle 0 → clr at 1, enable 2..1+G, capture at 2+G+S, done at 3+G+S.
- Latency, sequential mode: each channel occupies G+S+2 cycles, back to back; done one cycle after the last capture.
- abort in any non-IDLE state: the next cycle is IDLE with all strobes/enable 0, aborted=1, busy=0. No capture or done pulse occurs; done_mask keeps the bits already set.
- abort in IDLE: no effect.
- abort and start in the same cycle: abort wins. If busy, the run aborts. If idle, start is ignored and no err pulse is generated.
- Gate counter has no wrap: gate_cycles=2^GATE_W-1 is legal and runs the full count.
- Reset mid-run: immediate return to reset state; enable drops asynchronously.

Test Plan:
- Concurrent, mode=0, mask=4'b1111, G=10, S=4, start at cycle 0 → clr=4'hF at 1; enable=4'hF cycles 2..11; capture=4'hF at 16; done at 17; done_mask=4'hF.
- Sequential, mode=1, mask=4'b0101, G=10, S=4 →
  - ch0: clr=4'b0001 at 1, enable 2..11, capture at 16.
  - ch2: clr=4'b0100 at 17, capture at 32, active_chan=2 during 17..32.
  - done at 33; enable never has more than one bit set.
- Rejects: start with mask=0 → err pulse, busy stays 0. Start with G=0 → err pulse. Start while busy → ignored, timing unchanged.
- Abort: sequential mask=4'b0011, abort asserted during ch1 GATE → next cycle enable=0, aborted=1, busy=0, no done pulse, done_mask=4'b0001.
- Simultaneous abort+start in IDLE → no state change, no err; asynchronous reset asserted during GATE → all outputs 0 immediately.
- G=1, S=1 concurrent → enable high exactly one cycle (cycle 2), capture at 4, done at 5.
